reg_bank_arbiter: RTL and testbench

- Two-port round-robin arbiter that shares the SD host 32x32 register bank (REG) between the host-bus interface (port 0) and the SD command/data engine (port 1).
- Sequences the bank's 4-phase req/ack handshake, drives rw/addr/data_in, and returns data_out to the winning requester.
- A bounded-wait timer guarantees that a hung bank cannot stall either requester.

---
 rtl/reg_arb_pkg.sv | 20 ++
 rtl/reg_arb_timer.sv | 46 ++++
 rtl/reg_bank_arbiter.sv | 167 ++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register-bank arbiter.
// Holds the FSM state enum and the timer width helper.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    RELEASE,
    DONE
  } arb_state_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_TIMEOUT = 16;

  function automatic int tmr_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/reg_arb_timer.sv
// Saturating wait counter shared by the two handshake wait states.
// Flags expiry on the TIMEOUT-th enabled cycle; TIMEOUT=0 never expires.
module reg_arb_timer
  import reg_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = tmr_w(TIMEOUT);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_to
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
      assign expired_o = en_i && (cnt_q == LAST);
    end else begin : g_no_to
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin two-port arbiter in front of the 32x32 register bank.
// Runs the 4-phase req/ack handshake with a bounded wait per phase.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              reg_req,
  output logic              reg_rw,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic              owner
);

  arb_state_e        state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic              busy_q;
  logic              err_pend_q;
  logic              req_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              ack0_q, ack1_q;
  logic              err0_q, err1_q;

  logic win;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_exp;

  // On a tie the port that did not win last time is served.
  assign win = (req0 && req1) ? ~last_grant_q : req1;

  assign tmr_en = (state_q == WAIT_ACK) ||
                  (state_q == RELEASE);

  always_comb begin
    tmr_clr = 1'b1;
    unique case (state_q)
      WAIT_ACK: tmr_clr = reg_ack || tmr_exp;
      RELEASE:  tmr_clr = 1'b0;
      default:  tmr_clr = 1'b1;
    endcase
  end

  reg_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(tmr_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      err_pend_q   <= 1'b0;
      req_q        <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q <= win;
            rw_q    <= win ? rw1 : rw0;
            addr_q  <= win ? addr1 : addr0;
            wdata_q <= win ? wdata1 : wdata0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (reg_ack) begin
            if (!rw_q) begin
              if (owner_q) rdata1_q <= reg_rdata;
              else         rdata0_q <= reg_rdata;
            end
            req_q   <= 1'b0;
            state_q <= RELEASE;
          end else if (tmr_exp) begin
            err_pend_q <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= RELEASE;
          end
        end
        RELEASE: begin
          if (!reg_ack) begin
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            err0_q  <= ~owner_q & err_pend_q;
            err1_q  <= owner_q & err_pend_q;
            state_q <= DONE;
          end else if (tmr_exp) begin
            err_pend_q <= 1'b1;
            ack0_q     <= ~owner_q;
            ack1_q     <= owner_q;
            err0_q     <= ~owner_q;
            err1_q     <= owner_q;
            state_q    <= DONE;
          end
        end
        DONE: begin
          last_grant_q <= owner_q;
          busy_q       <= 1'b0;
          err_pend_q   <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign reg_req   = req_q;
  assign reg_rw    = rw_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural register bank.
// Expected completions and grants are queued at stimulus time.
module tb_reg_bank_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          reg_req, reg_rw, reg_ack;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic          busy, owner;

  always #5 clk = ~clk;

  reg_bank_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .reg_req(reg_req), .reg_rw(reg_rw),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  int            gq[$];
  logic [DW-1:0] refmem[32];
  logic [DW-1:0] exp_rd[2];
  int            checks = 0;
  int            passes = 0;
  int            fails = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 3) ? 32'hDEADBEEF : (32'hA5A5_0000 | 32'(i));
  endfunction

  // behavioural bank: programmable ack delay and ack hold
  int   ack_delay = 1;
  int   hold = 1;
  logic never_ack = 1'b0;
  logic [DW-1:0] mem[32];
  int   bst, bcnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      bst       <= 0;
      bcnt      <= 0;
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else begin
      case (bst)
        0: if (reg_req && !never_ack) begin
          bst  <= 1;
          bcnt <= ack_delay;
        end
        1: if (bcnt <= 1) begin
          reg_ack   <= 1'b1;
          reg_rdata <= mem[reg_addr];
          if (reg_rw) mem[reg_addr] <= reg_wdata;
          bcnt <= hold;
          bst  <= 2;
        end else begin
          bcnt <= bcnt - 1;
        end
        default: if (bcnt > 1) begin
          bcnt <= bcnt - 1;
        end else if (!reg_req) begin
          reg_ack <= 1'b0;
          bst     <= 0;
        end
      endcase
    end
  end

  // completion / grant monitor
  logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;
  logic prev_req = 1'b0, prev_rack = 1'b0;
  int   req_run = 0, req_len = 0;
  int   ack_run = 0, ack_len = 0;
  exp_t m_e;

  always @(negedge clk) begin
    if (reset) begin
      if (ack0) begin
        chk("ack0_width", 32'(prev_ack0), 32'd0);
        chk("ack0_after_bank_release", 32'(reg_ack), 32'd0);
        if (q0.size() == 0) begin
          chk("ack0_unexpected", 32'd1, 32'd0);
        end else begin
          m_e = q0.pop_front();
          chk("rdata0", rdata0, m_e.rd);
          chk("err0", 32'(err0), 32'(m_e.err));
        end
      end
      if (ack1) begin
        chk("ack1_width", 32'(prev_ack1), 32'd0);
        chk("ack1_after_bank_release", 32'(reg_ack), 32'd0);
        if (q1.size() == 0) begin
          chk("ack1_unexpected", 32'd1, 32'd0);
        end else begin
          m_e = q1.pop_front();
          chk("rdata1", rdata1, m_e.rd);
          chk("err1", 32'(err1), 32'(m_e.err));
        end
      end
      if (reg_req && !prev_req) begin
        if (gq.size() == 0) chk("grant_unexpected", 32'd1, 32'd0);
        else chk("grant_owner", 32'(owner), 32'(gq.pop_front()));
      end
    end
    prev_ack0 <= ack0;
    prev_ack1 <= ack1;
    prev_req  <= reg_req;
    prev_rack <= reg_ack;
    if (reg_req) req_run <= prev_req ? req_run + 1 : 1;
    else if (prev_req) req_len <= req_run;
    if (reg_ack) ack_run <= prev_rack ? ack_run + 1 : 1;
    else if (prev_rack) ack_len <= ack_run;
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) refmem[i] = init_val(i);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic expect_txn(input int p, input logic rw,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] d,
                            input logic to);
    exp_t e;
    gq.push_back(p);
    if (!to) begin
      if (rw) refmem[a] = d;
      else exp_rd[p] = refmem[a];
    end
    e.rd  = exp_rd[p];
    e.err = to;
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic issue(input int p, input logic rw,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bit got = 0;
    @(negedge clk);
    if (p == 0) begin
      rw0 = rw; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      rw1 = rw; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? ack0 : ack1;
    end
    if (!got) chk("ack_wait_expired", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_reg_req", 32'(reg_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    reset = 1'b1;

    // single read on port 0, latency of the grant
    expect_txn(0, 1'b0, 5'h03, '0, 1'b0);
    fork
      issue(0, 1'b0, 5'h03, '0);
      begin
        @(negedge clk);
        #1 chk("grant_not_early", 32'(reg_req), 32'd0);
        @(posedge clk);
        #1 chk("grant_one_cycle", 32'(reg_req), 32'd1);
      end
    join
    chk("t1_rdata0", rdata0, 32'hDEADBEEF);
    chk("t1_rdata1_kept", rdata1, 32'd0);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // simultaneous requests straight out of reset
    do_reset();
    expect_txn(0, 1'b1, 5'h01, 32'h11, 1'b0);
    expect_txn(1, 1'b0, 5'h01, '0, 1'b0);
    fork
      issue(0, 1'b1, 5'h01, 32'h11);
      issue(1, 1'b0, 5'h01, '0);
    join
    chk("t2_rdata1", rdata1, 32'h11);

    // continuous contention alternates ports
    expect_txn(0, 1'b0, 5'h02, '0, 1'b0);
    expect_txn(1, 1'b0, 5'h04, '0, 1'b0);
    expect_txn(0, 1'b1, 5'h05, 32'hCAFE0005, 1'b0);
    expect_txn(1, 1'b0, 5'h05, '0, 1'b0);
    fork
      begin
        issue(0, 1'b0, 5'h02, '0);
        issue(0, 1'b1, 5'h05, 32'hCAFE0005);
      end
      begin
        issue(1, 1'b0, 5'h04, '0);
        issue(1, 1'b0, 5'h05, '0);
      end
    join
    chk("t3_rdata1", rdata1, 32'hCAFE0005);

    // bank never answers
    never_ack = 1'b1;
    expect_txn(0, 1'b0, 5'h07, '0, 1'b1);
    issue(0, 1'b0, 5'h07, '0);
    chk("t4_req_len", 32'(req_len), 32'd16);
    chk("t4_rdata0_kept", rdata0, 32'h00000000 | refmem[2]);
    chk("t4_busy_low", 32'(busy), 32'd0);

    // reset while waiting on the bank
    gq.push_back(0);
    @(negedge clk);
    rw0 = 1'b0; addr0 = 5'h09; req0 = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_in_wait", 32'(reg_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_reg_req", 32'(reg_req), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ack0", 32'(ack0), 32'd0);
    req0 = 1'b0;
    never_ack = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    expect_txn(1, 1'b0, 5'h02, '0, 1'b0);
    issue(1, 1'b0, 5'h02, '0);
    chk("t5_rdata0_cleared", rdata0, 32'd0);

    // bank holds ack for several cycles
    hold = 5;
    expect_txn(0, 1'b0, 5'h03, '0, 1'b0);
    issue(0, 1'b0, 5'h03, '0);
    chk("t6_ack_len", 32'(ack_len), 32'd5);
    repeat (6) @(negedge clk);
    chk("end_q0_empty", 32'(q0.size()), 32'd0);
    chk("end_q1_empty", 32'(q1.size()), 32'd0);
    chk("end_gq_empty", 32'(gq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
